prog_clock_counter: RTL

//   Parametrised successor to the free-running 4-bit clock counter that drives the board LEDs.

---
 rtl/prog_clock_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/prog_clock_counter.sv
// Programmable LED clock counter: prescaled tick, configurable modulus, up/down,
// wrap/saturate/one-shot modes, synchronous load, terminal-count pulse and sticky overflow.
module prog_clock_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc,
    output logic             ovf,
    output logic             running
);

    localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    presc;

    logic             step_c;
    logic             at_bound_c;
    logic             halt_c;
    logic [WIDTH-1:0] bound_c;
    logic [WIDTH-1:0] next_out_c;
    logic [WIDTH-1:0] load_clamp_c;

    // Next count for a step, evaluated with the dir/mode present at the step.
    always_comb begin
        step_c       = en && (presc == PS_LAST);
        bound_c      = dir ? '0 : MAX_C;
        at_bound_c   = (out == bound_c);
        next_out_c   = out;
        halt_c       = 1'b0;
        load_clamp_c = (load_val > MAX_C) ? MAX_C : load_val;
        if (at_bound_c) begin
            case (mode)
                MODE_SAT:  next_out_c = out;
                MODE_ONCE: halt_c     = 1'b1;
                default:   next_out_c = dir ? MAX_C : '0;
            endcase
        end else begin
            next_out_c = dir ? (out - WIDTH'(1)) : (out + WIDTH'(1));
        end
    end

    // Prescaler, counter, RUN/HALT state and flags; priority rst > load > step.
    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= '0;
            presc   <= '0;
            tick    <= 1'b0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
            state   <= RUN;
            running <= 1'b1;
        end else begin
            // tick reflects prescaler rollover even in HALT or on a load cycle
            tick <= step_c;
            if (en) begin
                presc <= (presc == PS_LAST) ? '0 : (presc + PW'(1));
            end
            if (load) begin
                out     <= load_clamp_c;
                presc   <= '0;
                state   <= RUN;
                running <= 1'b1;
                tc      <= 1'b0;
                if (clr_ovf) begin
                    ovf <= 1'b0;
                end
            end else begin
                tc <= 1'b0;
                if (step_c && (state == RUN)) begin
                    out <= next_out_c;
                    if (at_bound_c) begin
                        tc <= 1'b1;
                    end
                    if (halt_c) begin
                        state   <= HALT;
                        running <= 1'b0;
                    end
                end
                if (step_c && (state == RUN) && at_bound_c) begin
                    ovf <= 1'b1;
                end else if (clr_ovf) begin
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule
